// File: rtl/dff_share_pkg.sv
// Shared types and default sizing for the shared-register arbiter slice.
package dff_share_pkg;

  // Arbitration FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared register: write requests, lane data,
// grant/ack handshake and the register contents broadcast back.
interface dff_share_arbiter_if
  import dff_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDW = $clog2(NREQ);

  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        owner;
  logic                  busy;

  modport master (
    output clr, req, wdata,
    input  gnt, ack, q, owner, busy
  );

  modport slave (
    input  clr, req, wdata,
    output gnt, ack, q, owner, busy
  );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping back to index 0 after NREQ-1.
module rr_pick
  import dff_share_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IDW:0]    off;
  logic [IDW:0]    sum;

  // Rotating the doubled vector puts requester ptr at bit 0, so the search is a plain priority scan.
  assign rot = NREQ'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the winner; add ptr back and wrap at NREQ.
  always_comb begin
    valid = 1'b0;
    off   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = (IDW+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// One WIDTH-bit register shared by NREQ requesters. A round-robin arbiter
// grants one requester, latches its lane, commits it to q and acks it.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rst,
  dff_share_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  gnt_r, gnt_nxt;
  logic [NREQ-1:0]  ack_r, ack_nxt;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_after;
  logic [IDW-1:0]   owner_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] q_r;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic             load_win;
  logic             latch_data;
  logic             do_commit;
  logic [WIDTH-1:0] lanes [NREQ];

  for (genvar li = 0; li < NREQ; li++) begin : g_lane
    assign lanes[li] = bus.wdata[li*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign ptr_after = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  // Next-state and next-handshake decode; clr aborts any open transaction.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = '0;
    ack_nxt    = '0;
    load_win   = 1'b0;
    latch_data = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << pick_idx;
          load_win  = 1'b1;
        end
      end
      GRANT: begin
        latch_data = 1'b1;
        if (bus.clr) begin
          state_nxt = IDLE;
        end else if (bus.req[win]) begin
          state_nxt = COMMIT;
          ack_nxt   = NREQ'(1) << win;
        end else begin
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        do_commit = !bus.clr;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered grant/ack bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_r <= '0;
      ack_r <= '0;
    end else begin
      state <= state_nxt;
      gnt_r <= gnt_nxt;
      ack_r <= ack_nxt;
    end
  end

  // Winner/data latches, the shared register, its owner and the rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win     <= '0;
      data_r  <= '0;
      q_r     <= '0;
      owner_r <= '0;
      ptr     <= '0;
    end else begin
      if (load_win) begin
        win <= pick_idx;
      end
      if (latch_data) begin
        data_r <= lanes[win];
      end
      if (bus.clr) begin
        q_r     <= '0;
        owner_r <= '0;
      end else if (do_commit) begin
        q_r     <= data_r;
        owner_r <= win;
        ptr     <= ptr_after;
      end
    end
  end

  // A clr in the COMMIT cycle cancels the write, so its ack is suppressed
  // in that same cycle; ack never depends on req.
  assign bus.ack   = bus.clr ? '0 : ack_r;
  assign bus.gnt   = gnt_r;
  assign bus.q     = q_r;
  assign bus.owner = owner_r;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: transaction-level reference
// model compared every cycle, plus directed scenarios with literal values.
module tb_dff_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dff_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = no transaction, 1 = granted, 2 = committing.
  int               m_stage;
  int               m_win;
  int               m_ptr;
  int               m_owner;
  int               m_w;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  e_gnt;
  logic [NREQ-1:0]  e_ack;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic c);
    bus.req   = r;
    bus.wdata = d;
    bus.clr   = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input string name, output logic [NREQ-1:0] a);
    a = '0;
    for (int n = 0; n < 12 && a == '0; n++) begin
      @(negedge clk);
      a = bus.ack;
    end
    if (a == '0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no ack within 12 cycles, one required", name);
    end
  endtask

  // Full single-requester write; checks the committed value and owner.
  task automatic doWrite(input int i, input logic [WIDTH-1:0] v);
    logic [NREQ*WIDTH-1:0] d;
    d = '0;
    d[i*WIDTH +: WIDTH] = v;
    applyStimulus(NREQ'(1) << i, d, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("write_q", 32'(bus.q), 32'(v));
    checkOutput("write_owner", 32'(bus.owner), 32'(i));
  endtask

  // Model advances on each edge from the spec rules; reset drops everything.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage = 0;
      m_win   = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_data  = '0;
      m_q     = '0;
    end else begin
      case (m_stage)
        0: begin
          m_w = -1;
          for (int k = 0; k < NREQ; k++) begin
            if (m_w < 0 && bus.req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
          end
          if (m_w >= 0) begin
            m_win   = m_w;
            m_stage = 1;
          end
        end
        1: begin
          m_data  = bus.wdata[m_win*WIDTH +: WIDTH];
          m_stage = (!bus.clr && bus.req[m_win]) ? 2 : 0;
        end
        default: begin
          if (!bus.clr) begin
            m_q     = m_data;
            m_owner = m_win;
            m_ptr   = (m_win + 1) % NREQ;
          end
          m_stage = 0;
        end
      endcase
      if (bus.clr) begin
        m_q     = '0;
        m_owner = 0;
      end
    end
  end

  // Compare DUT against the model mid-cycle whenever reset is not asserted.
  always @(negedge clk) begin
    if (!rst) begin
      e_gnt = (m_stage == 1) ? NREQ'(1) << m_win : '0;
      e_ack = (m_stage == 2 && !bus.clr) ? NREQ'(1) << m_win : '0;
      checkOutput("cmp_gnt", 32'(bus.gnt), 32'(e_gnt));
      checkOutput("cmp_ack", 32'(bus.ack), 32'(e_ack));
      checkOutput("cmp_busy", 32'(bus.busy), 32'(m_stage != 0));
      checkOutput("cmp_q", 32'(bus.q), 32'(m_q));
      checkOutput("cmp_owner", 32'(bus.owner), 32'(m_owner));
    end
  end

  initial begin
    logic [NREQ-1:0]       a;
    logic [NREQ-1:0]       seen;
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       exp_a;
    logic [WIDTH-1:0]      lane_v;
    time                   t_prev;

    rst = 1'b1;
    applyStimulus('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_q", 32'(bus.q), 32'h0);
    checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);

    $display("[TB] single request latency");
    applyStimulus(4'b0100, 32'h003C_0000, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("t2_gnt", 32'(bus.gnt), 32'h4);
    checkOutput("t2_busy_grant", 32'(bus.busy), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("t2_ack", 32'(bus.ack), 32'h4);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t2_q", 32'(bus.q), 32'h3C);
    checkOutput("t2_owner", 32'(bus.owner), 32'h2);
    checkOutput("t2_busy_low", 32'(bus.busy), 32'h0);

    $display("[TB] wrap-around from ptr=1");
    doWrite(0, 8'h5A);
    applyStimulus(4'b1001, 32'h7700_0088, 1'b0);
    waitAck("t4_first", a);
    checkOutput("t4_first_ack", 32'(a), 32'h8);
    tick();
    applyStimulus(4'b0001, 32'h7700_0088, 1'b0);
    waitAck("t4_second", a);
    checkOutput("t4_second_ack", 32'(a), 32'h1);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t4_q", 32'(bus.q), 32'h88);
    checkOutput("t4_owner", 32'(bus.owner), 32'h0);

    $display("[TB] withdrawal during grant");
    applyStimulus(4'b0010, 32'h0000_9900, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("t5_gnt", 32'(bus.gnt), 32'h2);
    applyStimulus('0, 32'h0000_9900, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("t5_busy", 32'(bus.busy), 32'h0);
    checkOutput("t5_ack", 32'(bus.ack), 32'h0);
    checkOutput("t5_q", 32'(bus.q), 32'h88);
    applyStimulus(4'b0011, 32'h0000_1122, 1'b0);
    waitAck("t5_rearb", a);
    checkOutput("t5_ptr_kept", 32'(a), 32'h2);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t5_q_after", 32'(bus.q), 32'h11);
    checkOutput("t5_owner_after", 32'(bus.owner), 32'h1);

    $display("[TB] clear during commit and in idle");
    applyStimulus(4'b0100, 32'h00FF_0000, 1'b0);
    tick();
    tick();
    applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    checkOutput("t6_ack_suppressed", 32'(bus.ack), 32'h0);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t6_q_cleared", 32'(bus.q), 32'h0);
    checkOutput("t6_owner_cleared", 32'(bus.owner), 32'h0);
    doWrite(1, 8'h55);
    applyStimulus('0, '0, 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t6_idle_clr_q", 32'(bus.q), 32'h0);
    checkOutput("t6_idle_clr_owner", 32'(bus.owner), 32'h0);

    $display("[TB] reset mid-grant");
    doWrite(3, 8'h6E);
    applyStimulus(4'b0010, 32'h0000_A500, 1'b0);
    tick();
    #1 rst = 1'b1;
    #1;
    checkOutput("t1_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("t1_ack", 32'(bus.ack), 32'h0);
    checkOutput("t1_busy", 32'(bus.busy), 32'h0);
    checkOutput("t1_q", 32'(bus.q), 32'h0);
    checkOutput("t1_owner", 32'(bus.owner), 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput("t1_no_ack", 32'(bus.ack), 32'h0);
    end

    $display("[TB] all requesters held from reset");
    rst = 1'b1;
    tick();
    applyStimulus(4'b1111, 32'h4433_2211, 1'b0);
    rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      exp_a  = NREQ'(1) << (k % NREQ);
      lane_v = WIDTH'(8'h11 * ((k % NREQ) + 1));
      waitAck("t3_ack", a);
      checkOutput("t3_order", 32'(a), 32'(exp_a));
      if (k > 0) checkOutput("t3_spacing", 32'($time - t_prev), 32'd30);
      t_prev = $time;
      @(negedge clk);
      checkOutput("t3_q", 32'(bus.q), 32'(lane_v));
      checkOutput("t3_owner", 32'(bus.owner), 32'(k % NREQ));
    end
    applyStimulus('0, '0, 1'b0);
    repeat (3) tick();

    $display("[TB] randomized traffic");
    seen = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      seen = bus.ack;
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      r = bus.req;
      d = bus.wdata;
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) begin
          if (seen[i] && $urandom_range(0, 3) != 0) r[i] = 1'b0;
          else if ($urandom_range(0, 49) == 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
          d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      applyStimulus(r, d, $urandom_range(0, 29) == 0);
    end
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Shares one WIDTH-bit register (the team's D flip-flop bank, reset-to-0, load-on-clock) between NREQ requesters.
- Requesters raise req with write data. A round-robin arbiter picks one, grants it, loads the register and acknowledges.
- Sits between requester blocks and the shared register; the register lives inside this block.
- q is visible to every requester at all times.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, width of the shared register and of each write-data lane
IDW, $clog2(NREQ), width of the owner index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear of the register, highest priority after rst
req  input  NREQ  per-requester write request; level, held until ack
wdata  input  NREQ*WIDTH  lane i = wdata[i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, at most one bit set
ack  output  NREQ  one-cycle pulse when the requester's write has committed
q  output  WIDTH  shared register contents
owner  output  IDW  index of the last requester that committed a write
busy  output  1  high while in GRANT or COMMIT

Behaviour:
- Reset (rst=1, async): state=IDLE, gnt=0, ack=0, q=0, owner=0, busy=0, rr pointer=0, data latch=0. Takes effect mid-transaction: the transaction is dropped and no ack is issued.
- FSM states: IDLE, GRANT, COMMIT.
- IDLE: if req != 0, select the winner w = first set req bit searching from ptr upward, wrapping modulo NREQ. Latch w; next state GRANT. With no request, stay in IDLE.
- GRANT: gnt[w]=1 and busy=1; latch wdata lane w.
  - If req[w]=1 in this cycle, go to COMMIT.
  - If req[w]=0 (requester withdrew), go to IDLE. No write, no ack, ptr unchanged.
- COMMIT: gnt=0, busy=1.
  - On this cycle's clock edge: q <= latched data, owner <= w, ptr <= (w+1) mod NREQ.
  - ack[w]=1 for exactly this cycle. Next state IDLE.
- Timing: req sampled at edge N; gnt visible in cycle N+1; q and owner updated at edge N+2, with ack high during cycle N+2. Minimum of 3 cycles between successive commits.
- Fairness: a continuously asserted req is served within NREQ transactions.
- Requester rule: req must stay high until ack. The requester may deassert req in the cycle after ack; if req is still high in IDLE, it is rearbitrated.
- clr=1 (sync):
  - q <= 0 and owner <= 0.
  - In GRANT or COMMIT the transaction is aborted: state <= IDLE, no ack, ptr unchanged.
  - clr overrides a same-cycle commit.
- gnt and ack are registered outputs, never combinational from req.
- NREQ not a power of 2: the pointer wraps from NREQ-1 to 0. Indices >= NREQ are never granted.

Decomposition:
- Package dff_share_pkg: state enum (IDLE, GRANT, COMMIT) as a 2-bit typedef, plus a localparam default WIDTH/NREQ.
- Sub-module rr_pick: combinational round-robin selector. Inputs req[NREQ] and ptr[IDW]; outputs idx[IDW] and valid.
- Top module holds the FSM, data latch, shared register, owner register and pointer.

Test Plan:
1. rst=1 mid-GRANT with req=4'b0010, wdata lane1=8'hA5 -> gnt, ack, busy, q and owner all 0 immediately; after release, no ack for the aborted write.
2. Single request req=4'b0100, lane2=8'h3C at edge 0 -> gnt=4'b0100 in cycle 1; q=8'h3C, owner=2, ack=4'b0100 in cycle 2; busy low in cycle 3.
3. All four req held high from reset -> commits occur in order 0,1,2,3,0 every 3 cycles, and q follows each lane's data.
4. req=4'b1001 with ptr=1 -> requester 3 is granted first, then requester 0 (wrap-around).
5. Requester 1 drops req during GRANT -> no ack, q unchanged, returns to IDLE, and the next arbitration still starts from the old ptr.
6. clr=1 in a COMMIT cycle with lane data 8'hFF -> q=0, no ack; a clr pulse in IDLE with q=8'h55 -> q=0, owner=0.
